// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder pipeline and its window accumulator.
// Used by window_accumulator and accum_sat_add.
package adder_pkg;

    typedef enum logic {ACC_ACCUM, ACC_HOLD} acc_state_t;

    // Signed limit for a w-bit two's-complement value (w <= 64); callers slice the low w bits.
    function automatic logic [63:0] sat_limit(input int unsigned w, input logic negative);
        logic [63:0] max_val;
        max_val = (64'd1 << (w - 1)) - 64'd1;
        return negative ? ~max_val : max_val;
    endfunction

endpackage

// File: rtl/window_accumulator_if.sv
// Sample-in / window-sum-out handshake bundle for window_accumulator.
// The slave modport is the accumulator side; master is the upstream/downstream side.
interface window_accumulator_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] data_out;
    logic                 overflow;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, overflow
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, overflow
    );
endinterface

// File: rtl/accum_sat_add.sv
// Combinational ACC_WIDTH-bit signed add with overflow detect.
// Macro ACC_SATURATE_EN: clamp to the signed limits on overflow instead of wrapping.
module accum_sat_add
    import adder_pkg::*;
#(
    parameter int ACC_WIDTH = 40
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);
`ifdef ACC_SATURATE_EN
    localparam logic [63:0]          MAX64 = sat_limit(ACC_WIDTH, 1'b0);
    localparam logic [63:0]          MIN64 = sat_limit(ACC_WIDTH, 1'b1);
    localparam logic [ACC_WIDTH-1:0] MAX_V = MAX64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] MIN_V = MIN64[ACC_WIDTH-1:0];
`endif

    logic [ACC_WIDTH-1:0] raw;

    // Overflow means equal-sign operands produced a result of the other sign.
    always_comb begin
        raw = a + b;
        ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
`ifdef ACC_SATURATE_EN
        if (ovf) begin
            sum = a[ACC_WIDTH-1] ? MIN_V : MAX_V;
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end
endmodule

// File: rtl/window_accumulator.sv
// Sums COUNT accepted signed samples per window and offers each total over valid/ready.
// Macro ACC_SATURATE_EN (in accum_sat_add) selects saturating instead of wrapping adds.
module window_accumulator
    import adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int COUNT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    window_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(COUNT + 1);

    acc_state_t           state;
    acc_state_t           next_state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sticky;
    logic [ACC_WIDTH-1:0] result;
    logic                 result_ovf;

    logic [ACC_WIDTH-1:0] sample_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_ovf;
    logic                 accept;
    logic                 last;

    assign sample_ext = ACC_WIDTH'($signed(bus.data_in));
    assign accept     = bus.in_valid && (state == ACC_ACCUM);
    assign last       = (cnt == CNT_W'(COUNT - 1));

    accum_sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_add (
        .a   (acc),
        .b   (sample_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACC_ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Handshake flags come from state alone, so out_ready never reaches in_ready combinationally.
    always_comb begin
        next_state    = state;
        bus.in_ready  = (state == ACC_ACCUM);
        bus.out_valid = (state == ACC_HOLD);
        if (clr) begin
            next_state = ACC_ACCUM;
        end else begin
            case (state)
                ACC_ACCUM: if (accept && last) next_state = ACC_HOLD;
                ACC_HOLD:  if (bus.out_ready)  next_state = ACC_ACCUM;
                default:   next_state = ACC_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            result     <= '0;
            result_ovf <= 1'b0;
        end else if (clr) begin
            acc        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            result     <= '0;
            result_ovf <= 1'b0;
        end else if (accept) begin
            if (last) begin
                result     <= sum;
                result_ovf <= sticky | add_ovf;
                acc        <= '0;
                cnt        <= '0;
                sticky     <= 1'b0;
            end else begin
                acc    <= sum;
                cnt    <= cnt + CNT_W'(1);
                sticky <= sticky | add_ovf;
            end
        end
    end

    assign bus.data_out = result;
    assign bus.overflow = result_ovf;
endmodule

// File: doc/window_accumulator.md
# window_accumulator

Downstream stage of the three-term adder pipeline. Consumes its WIDTH-bit signed result, sums COUNT consecutive accepted samples into a wider accumulator, and hands each window total out over a valid/ready handshake. A per-window overflow flag is produced. In the test designs it feeds the output capture/compare logic.

## Interface
- WIDTH, 32, input sample width; matches the upstream adder's data_out.
- ACC_WIDTH, 40, accumulator and result width; must be >= WIDTH.
- COUNT, 16, samples per window; must be >= 1. The counter width is the localparam $clog2(COUNT+1).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; discards the partial window and any pending result.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- data_in  input  WIDTH  two's-complement sample.
- out_valid  output  1  data_out holds a completed window sum.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  ACC_WIDTH  signed window sum.
- overflow  output  1  signed overflow occurred in the window now presented; valid while out_valid is high.

## Operation
- Accept condition: in_valid && in_ready. Each accepted sample is sign-extended to ACC_WIDTH and added to acc. cnt then increments.
- FSM state ACCUM:
  - in_ready=1 and out_valid=0.
  - When the accepted sample is the one with cnt==COUNT-1, register data_out = acc + sample and overflow = sticky | this-add-overflow. Go to HOLD.
  - acc, cnt and sticky clear in the same edge.
- FSM state HOLD:
  - in_ready=0 and out_valid=1. data_out and overflow are held stable.
  - Samples presented here are ignored, not queued.
  - On out_ready=1, out_valid falls at the next edge and the FSM returns to ACCUM.
- Overflow: signed overflow on any add in the window, meaning operands of equal sign and a result of different sign in ACC_WIDTH bits.
- clr has priority over every other input. At the next edge:
  - acc=0, cnt=0, sticky=0.
  - out_valid=0, data_out=0, overflow=0.
  - State returns to ACCUM.
  - A sample presented in the clr cycle is dropped.
- COUNT=1: every accepted sample goes straight to HOLD, and data_out equals the sign-extended sample.
- rst asserted mid-window or mid-HOLD: immediate return to the reset state. No result is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, data_out=0, overflow=0, state ACCUM, acc=0, cnt=0.
- Latency: out_valid rises on the edge that accepts the COUNT-th sample, so it is visible the cycle after that sample.
- Throughput: one window per COUNT+1 cycles at minimum, because HOLD lasts at least one cycle.
- out_valid is never deasserted without out_ready or clr. data_out does not change while out_valid=1.
- in_ready depends only on state. There is no combinational path from out_ready to in_ready.

## Configuration
- ACC_SATURATE_EN defined:
  - Each add clamps on overflow to 2^(ACC_WIDTH-1)-1 when positive, or -2^(ACC_WIDTH-1) when negative.
  - Further adds continue from the clamped value.
  - overflow still reports the event.
- ACC_SATURATE_EN undefined:
  - Adds wrap modulo 2^ACC_WIDTH.
  - overflow reports the event.

## Structure
- Shared package adder_pkg holds:
  - typedef enum of the FSM states {ACC_ACCUM, ACC_HOLD};
  - the helper that returns the signed max/min constants for a given width.
- One sub-module is natural: accum_sat_add. It is combinational with inputs a, b (ACC_WIDTH) and outputs sum and ovf, and it holds the ACC_SATURATE_EN ifdef.
- The top level holds the FSM, the counter and the registers.

## Test plan
- Reset behaviour: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, data_out=0, overflow=0. No sample is counted after release.
- Basic sum (COUNT=4): samples 1, 2, 3, 4 on consecutive cycles -> out_valid=1 the next cycle, data_out=10, overflow=0.
- Negative values (COUNT=4, ACC_WIDTH=40): four samples of 0xFFFFFFFF -> data_out=0xFFFFFFFFFC (-4), overflow=0.
- Back-pressure:
  - Setup: COUNT=4; out_ready=0 for 5 cycles after the result while in_valid=1 with value 7.
  - During the stall: data_out is stable, in_ready=0.
  - After out_ready=1: the next window of 5, 5, 5, 5 gives 20.
- Overflow (WIDTH=ACC_WIDTH=32, COUNT=2): two samples of 0x7FFFFFFF ->
  - without the macro: data_out=0xFFFFFFFE;
  - with ACC_SATURATE_EN: data_out=0x7FFFFFFF;
  - overflow=1 in both builds.
- clr mid-window (COUNT=4): 100, 200, then clr, then 1, 1, 1, 1 -> data_out=4. No result is emitted for the aborted window.
